// File: rtl/mrv1_pkg.sv
// mrv1_pkg
// Shared definitions for the MRV1 per-thread instruction queue.
// Holds the default thread count and tag width, the tag and thread-id types
// built from those defaults, and the helper that derives the queue depth
// from a tag width.
package mrv1_pkg;

    localparam int NUM_THREADS_DEF = 8;
    localparam int ITAG_WIDTH_DEF  = 3;
    localparam int TID_WIDTH_DEF   = $clog2(NUM_THREADS_DEF);

    typedef logic [ITAG_WIDTH_DEF-1:0] itag_t;
    typedef logic [TID_WIDTH_DEF-1:0]  tid_t;

    // Queue depth per thread: one entry per distinct tag value.
    function automatic int iq_size(input int itag_width);
        return 2 ** itag_width;
    endfunction

endpackage

// File: rtl/mrv1_iqueue_thread.sv
// mrv1_iqueue_thread
// One thread's instruction-queue ring.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   flush_i               empty the ring on the next edge (wins over dsp/retire)
//   dsp_vld_i             dispatch aimed at this thread (already demuxed)
//   dsp_rd_vld_i/addr_i   destination register info of the dispatched entry
//   dsp_rdy_o             ring not full
//   tail_o                tag the next dispatch will receive
//   retire_vld_i/cnt_i    retire cnt entries from the head
//   retire_rdy_o          at least one entry in flight
//   head_o                tag of the oldest entry
//   rd_vld_o/rd_addr_o    per-entry destination info (rd_vld masked by valid)
module mrv1_iqueue_thread
    import mrv1_pkg::*;
#(
    parameter  int ITAG_WIDTH_P    = ITAG_WIDTH_DEF,
    parameter  int rf_addr_width_p = 5,
    localparam int IQ_SIZE_LP      = iq_size(ITAG_WIDTH_P)
) (
    input  logic                                         clk_i,
    input  logic                                         rst_i,
    input  logic                                         flush_i,
    input  logic                                         dsp_vld_i,
    input  logic                                         dsp_rd_vld_i,
    input  logic [rf_addr_width_p-1:0]                   dsp_rd_addr_i,
    output logic                                         dsp_rdy_o,
    output logic [ITAG_WIDTH_P-1:0]                      tail_o,
    input  logic                                         retire_vld_i,
    input  logic [ITAG_WIDTH_P:0]                        retire_cnt_i,
    output logic                                         retire_rdy_o,
    output logic [ITAG_WIDTH_P-1:0]                      head_o,
    output logic [IQ_SIZE_LP-1:0]                        rd_vld_o,
    output logic [IQ_SIZE_LP-1:0][rf_addr_width_p-1:0]   rd_addr_o
);

    localparam logic [ITAG_WIDTH_P:0] FULL_CNT = (ITAG_WIDTH_P+1)'(IQ_SIZE_LP);

    logic [ITAG_WIDTH_P-1:0]                     head_q, head_d;
    logic [ITAG_WIDTH_P-1:0]                     tail_q, tail_d;
    logic [ITAG_WIDTH_P:0]                       count_q, count_d;
    logic [IQ_SIZE_LP-1:0]                       valid_q, valid_d;
    logic [IQ_SIZE_LP-1:0]                       rd_vld_q, rd_vld_d;
    logic [IQ_SIZE_LP-1:0][rf_addr_width_p-1:0]  rd_addr_q, rd_addr_d;

    logic                    dsp_fire;
    logic [ITAG_WIDTH_P:0]   ret_cnt;
    logic [ITAG_WIDTH_P-1:0] offset;

    assign dsp_rdy_o    = (count_q != FULL_CNT);
    assign retire_rdy_o = (count_q != '0);
    assign head_o       = head_q;
    assign tail_o       = tail_q;
    assign rd_vld_o     = valid_q & rd_vld_q;
    assign rd_addr_o    = rd_addr_q;

    // Dispatch is gated by the pre-edge full flag, so a same-cycle retire on
    // a full ring does not open a slot until the following cycle.
    assign dsp_fire = dsp_vld_i && dsp_rdy_o;

    // Over-retire is illegal upstream; clamp so the counter can never wrap.
    assign ret_cnt = !retire_vld_i             ? '0      :
                     (retire_cnt_i > count_q)  ? count_q : retire_cnt_i;

    always_comb begin
        head_d    = head_q + ret_cnt[ITAG_WIDTH_P-1:0];
        tail_d    = tail_q + ITAG_WIDTH_P'(dsp_fire);
        count_d   = count_q + (ITAG_WIDTH_P+1)'(dsp_fire) - ret_cnt;
        valid_d   = valid_q;
        rd_vld_d  = rd_vld_q;
        rd_addr_d = rd_addr_q;
        offset    = '0;
        // An entry retires when its distance from the head (mod ring size)
        // is below the retire count.
        for (int i = 0; i < IQ_SIZE_LP; i++) begin
            offset = ITAG_WIDTH_P'(i) - head_q;
            if ({1'b0, offset} < ret_cnt) begin
                valid_d[i] = 1'b0;
            end
        end
        // The tail slot is never inside the retiring range when not full.
        if (dsp_fire) begin
            valid_d[tail_q]   = 1'b1;
            rd_vld_d[tail_q]  = dsp_rd_vld_i;
            rd_addr_d[tail_q] = dsp_rd_addr_i;
        end
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            valid_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // Payload storage is qualified by valid_q, so it carries no reset.
    always_ff @(posedge clk_i) begin
        rd_vld_q  <= rd_vld_d;
        rd_addr_q <= rd_addr_d;
    end

endmodule

// File: rtl/mrv1_iqueue.sv
// mrv1_iqueue
// Multi-thread instruction queue: one ring per hardware thread.
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   dsp_*                    single dispatch port, demuxed by dsp_tid_i;
//                            dsp_itag_o is the tail tag of dsp_tid_i
//   dsp_rdy_o                per-thread not-full
//   retire_vld_i/cnt_i       per-thread retire strobe and count
//   retire_rdy_o/itag_o      per-thread non-empty flag and head tag
//   iq_rd_vld_o/iq_rd_addr_o per-entry destination register info
//   flush_i                  per-thread flush
//   qry_tid_i/addr_i         register scoreboard query; qry_busy_o set when a
//                            valid entry of that thread writes that register
module mrv1_iqueue
    import mrv1_pkg::*;
#(
    parameter  int NUM_THREADS_P   = NUM_THREADS_DEF,
    parameter  int ITAG_WIDTH_P    = ITAG_WIDTH_DEF,
    parameter  int rf_addr_width_p = 5,
    localparam int IQ_SIZE_LP      = iq_size(ITAG_WIDTH_P),
    localparam int TID_WIDTH_LP    = $clog2(NUM_THREADS_P)
) (
    input  logic                                                        clk_i,
    input  logic                                                        rst_i,
    input  logic                                                        dsp_vld_i,
    input  logic [TID_WIDTH_LP-1:0]                                     dsp_tid_i,
    input  logic                                                        dsp_rd_vld_i,
    input  logic [rf_addr_width_p-1:0]                                  dsp_rd_addr_i,
    output logic [NUM_THREADS_P-1:0]                                    dsp_rdy_o,
    output logic [ITAG_WIDTH_P-1:0]                                     dsp_itag_o,
    input  logic [NUM_THREADS_P-1:0]                                    retire_vld_i,
    input  logic [NUM_THREADS_P-1:0][ITAG_WIDTH_P:0]                    retire_cnt_i,
    output logic [NUM_THREADS_P-1:0]                                    retire_rdy_o,
    output logic [NUM_THREADS_P-1:0][ITAG_WIDTH_P-1:0]                  retire_itag_o,
    output logic [NUM_THREADS_P-1:0][IQ_SIZE_LP-1:0]                    iq_rd_vld_o,
    output logic [NUM_THREADS_P-1:0][IQ_SIZE_LP-1:0][rf_addr_width_p-1:0] iq_rd_addr_o,
    input  logic [NUM_THREADS_P-1:0]                                    flush_i,
    input  logic [TID_WIDTH_LP-1:0]                                     qry_tid_i,
    input  logic [rf_addr_width_p-1:0]                                  qry_addr_i,
    output logic                                                        qry_busy_o
);

    logic [NUM_THREADS_P-1:0][ITAG_WIDTH_P-1:0] tail_w;

    for (genvar t = 0; t < NUM_THREADS_P; t++) begin : g_thread
        mrv1_iqueue_thread #(
            .ITAG_WIDTH_P    (ITAG_WIDTH_P),
            .rf_addr_width_p (rf_addr_width_p)
        ) u_thread (
            .clk_i         (clk_i),
            .rst_i         (rst_i),
            .flush_i       (flush_i[t]),
            .dsp_vld_i     (dsp_vld_i && (dsp_tid_i == TID_WIDTH_LP'(t))),
            .dsp_rd_vld_i  (dsp_rd_vld_i),
            .dsp_rd_addr_i (dsp_rd_addr_i),
            .dsp_rdy_o     (dsp_rdy_o[t]),
            .tail_o        (tail_w[t]),
            .retire_vld_i  (retire_vld_i[t]),
            .retire_cnt_i  (retire_cnt_i[t]),
            .retire_rdy_o  (retire_rdy_o[t]),
            .head_o        (retire_itag_o[t]),
            .rd_vld_o      (iq_rd_vld_o[t]),
            .rd_addr_o     (iq_rd_addr_o[t])
        );
    end

    assign dsp_itag_o = tail_w[dsp_tid_i];

    // x0 is hardwired zero, so it never has a pending writer.
    always_comb begin
        qry_busy_o = 1'b0;
        for (int e = 0; e < IQ_SIZE_LP; e++) begin
            if (iq_rd_vld_o[qry_tid_i][e] &&
                (iq_rd_addr_o[qry_tid_i][e] == qry_addr_i)) begin
                qry_busy_o = 1'b1;
            end
        end
        if (qry_addr_i == '0) begin
            qry_busy_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_mrv1_iqueue.sv
// tb_mrv1_iqueue
// Self-checking bench for mrv1_iqueue. A small occupancy/tail model tracks
// each thread; dispatched tags and rd addresses go into scoreboard queues
// and are popped when the DUT presents them.
module tb_mrv1_iqueue;
    import mrv1_pkg::*;

    localparam int NT = 8;
    localparam int IW = 3;
    localparam int RW = 5;
    localparam int IQ = 8;
    localparam int TW = 3;

    logic                          clk;
    logic                          rst;
    logic                          dsp_vld;
    logic [TW-1:0]                 dsp_tid;
    logic                          dsp_rd_vld;
    logic [RW-1:0]                 dsp_rd_addr;
    logic [NT-1:0]                 dsp_rdy;
    logic [IW-1:0]                 dsp_itag;
    logic [NT-1:0]                 retire_vld;
    logic [NT-1:0][IW:0]           retire_cnt;
    logic [NT-1:0]                 retire_rdy;
    logic [NT-1:0][IW-1:0]         retire_itag;
    logic [NT-1:0][IQ-1:0]         iq_rd_vld;
    logic [NT-1:0][IQ-1:0][RW-1:0] iq_rd_addr;
    logic [NT-1:0]                 flush;
    logic [TW-1:0]                 qry_tid;
    logic [RW-1:0]                 qry_addr;
    logic                          qry_busy;

    int n_tests = 0;
    int n_fail  = 0;
    int mcount[NT];
    int mtail[NT];
    itag_t         itag_q[$];
    logic [RW-1:0] addr_q[$];

    mrv1_iqueue dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .dsp_vld_i     (dsp_vld),
        .dsp_tid_i     (dsp_tid),
        .dsp_rd_vld_i  (dsp_rd_vld),
        .dsp_rd_addr_i (dsp_rd_addr),
        .dsp_rdy_o     (dsp_rdy),
        .dsp_itag_o    (dsp_itag),
        .retire_vld_i  (retire_vld),
        .retire_cnt_i  (retire_cnt),
        .retire_rdy_o  (retire_rdy),
        .retire_itag_o (retire_itag),
        .iq_rd_vld_o   (iq_rd_vld),
        .iq_rd_addr_o  (iq_rd_addr),
        .flush_i       (flush),
        .qry_tid_i     (qry_tid),
        .qry_addr_i    (qry_addr),
        .qry_busy_o    (qry_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        dsp_vld     = 1'b0;
        dsp_tid     = '0;
        dsp_rd_vld  = 1'b0;
        dsp_rd_addr = '0;
        retire_vld  = '0;
        retire_cnt  = '0;
        flush       = '0;
        qry_tid     = '0;
        qry_addr    = '0;
    endtask

    // Advance one clock: update the model from the pre-edge inputs, wait for
    // the edge, settle, then drop all strobes.
    task automatic step();
        for (int t = 0; t < NT; t++) begin
            int c;
            bit fire;
            if (rst || flush[t]) begin
                mcount[t] = 0;
                mtail[t]  = 0;
            end else begin
                fire = dsp_vld && (int'(dsp_tid) == t) && (mcount[t] != IQ);
                c    = retire_vld[t] ? int'(retire_cnt[t]) : 0;
                if (c > mcount[t]) $error("[TB] illegal retire count on thread %0d", t);
                mcount[t] = mcount[t] + int'(fire) - c;
                if (fire) mtail[t] = (mtail[t] + 1) % IQ;
            end
        end
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    // Drive a dispatch and record the tag the model expects for it.
    task automatic applyStimulus(input int tid, input bit rdv, input int rd);
        dsp_vld     = 1'b1;
        dsp_tid     = TW'(tid);
        dsp_rd_vld  = rdv;
        dsp_rd_addr = RW'(rd);
        itag_q.push_back(itag_t'(mtail[tid]));
        addr_q.push_back(RW'(rd));
    endtask

    task automatic test_reset();
        itag_t exp;
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_tests++;
        if (dsp_rdy !== 8'hFF) begin n_fail++; $display("[TB] FAIL reset_dsp_rdy got %h exp ff", dsp_rdy); end
        n_tests++;
        if (retire_rdy !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_retire_rdy got %h exp 00", retire_rdy); end
        n_tests++;
        if (retire_itag !== '0) begin n_fail++; $display("[TB] FAIL reset_retire_itag got %h exp 0", retire_itag); end
        n_tests++;
        if (iq_rd_vld !== '0) begin n_fail++; $display("[TB] FAIL reset_iq_rd_vld got %h exp 0", iq_rd_vld); end
        n_tests++;
        if (qry_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_qry_busy got %b exp 0", qry_busy); end
        itag_q.delete();
        addr_q.delete();
        exp = '0;
        dsp_tid = 3'd4;
        #1;
        n_tests++;
        if (dsp_itag !== exp) begin n_fail++; $display("[TB] FAIL reset_dsp_itag got %0d exp %0d", dsp_itag, exp); end
    endtask

    task automatic test_fill();
        itag_t         exp;
        logic [RW-1:0] exp_a;
        for (int i = 0; i < IQ; i++) begin
            applyStimulus(2, 1'b1, i + 1);
            #1;
            exp = itag_q.pop_front();
            n_tests++;
            if (dsp_itag !== exp) begin n_fail++; $display("[TB] FAIL fill_itag[%0d] got %0d exp %0d", i, dsp_itag, exp); end
            step();
        end
        n_tests++;
        if (dsp_rdy !== 8'hFB) begin n_fail++; $display("[TB] FAIL fill_dsp_rdy got %h exp fb", dsp_rdy); end
        n_tests++;
        if (retire_rdy !== 8'h04) begin n_fail++; $display("[TB] FAIL fill_retire_rdy got %h exp 04", retire_rdy); end
        n_tests++;
        if (iq_rd_vld[2] !== 8'hFF) begin n_fail++; $display("[TB] FAIL fill_rd_vld got %h exp ff", iq_rd_vld[2]); end
        for (int e = 0; e < IQ; e++) begin
            exp_a = addr_q.pop_front();
            n_tests++;
            if (iq_rd_addr[2][e] !== exp_a) begin n_fail++; $display("[TB] FAIL fill_rd_addr[%0d] got %0d exp %0d", e, iq_rd_addr[2][e], exp_a); end
        end
    endtask

    task automatic test_full_ignore();
        applyStimulus(2, 1'b1, 20);
        void'(itag_q.pop_back());
        void'(addr_q.pop_back());
        #1;
        n_tests++;
        if (dsp_rdy[2] !== 1'b0) begin n_fail++; $display("[TB] FAIL full_rdy_pre got %b exp 0", dsp_rdy[2]); end
        step();
        dsp_tid = 3'd2;
        #1;
        n_tests++;
        if (dsp_itag !== 3'd0) begin n_fail++; $display("[TB] FAIL full_tail got %0d exp 0", dsp_itag); end
        n_tests++;
        if (dsp_rdy[2] !== (mcount[2] != IQ)) begin n_fail++; $display("[TB] FAIL full_count_rdy got %b exp %b", dsp_rdy[2], mcount[2] != IQ); end
        n_tests++;
        if (iq_rd_addr[2][0] !== 5'd1) begin n_fail++; $display("[TB] FAIL full_entry0 got %0d exp 1", iq_rd_addr[2][0]); end
    endtask

    task automatic test_retire_wrap();
        itag_t exp;
        retire_vld[2] = 1'b1;
        retire_cnt[2] = 4'd6;
        step();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(2, 1'b1, 9 + i);
            #1;
            exp = itag_q.pop_front();
            void'(addr_q.pop_front());
            n_tests++;
            if (dsp_itag !== exp) begin n_fail++; $display("[TB] FAIL wrap_itag[%0d] got %0d exp %0d", i, dsp_itag, exp); end
            step();
        end
        n_tests++;
        if (retire_itag[2] !== 3'd6) begin n_fail++; $display("[TB] FAIL wrap_head6 got %0d exp 6", retire_itag[2]); end
        n_tests++;
        if (iq_rd_vld[2] !== 8'b1100_0011) begin n_fail++; $display("[TB] FAIL wrap_vld_pre got %b exp 11000011", iq_rd_vld[2]); end
        retire_vld[2] = 1'b1;
        retire_cnt[2] = 4'd0;
        step();
        n_tests++;
        if (retire_itag[2] !== 3'd6) begin n_fail++; $display("[TB] FAIL wrap_cnt0_noop got %0d exp 6", retire_itag[2]); end
        retire_vld[2] = 1'b1;
        retire_cnt[2] = 4'd3;
        step();
        n_tests++;
        if (retire_itag[2] !== 3'd1) begin n_fail++; $display("[TB] FAIL wrap_head1 got %0d exp 1", retire_itag[2]); end
        n_tests++;
        if (iq_rd_vld[2] !== 8'b0000_0010) begin n_fail++; $display("[TB] FAIL wrap_vld_post got %b exp 00000010", iq_rd_vld[2]); end
        n_tests++;
        if (retire_rdy[2] !== 1'b1 || dsp_rdy[2] !== 1'b1) begin n_fail++; $display("[TB] FAIL wrap_rdy got %b%b exp 11", retire_rdy[2], dsp_rdy[2]); end
    endtask

    task automatic test_full_retire_dispatch();
        itag_t exp;
        for (int i = 0; i < IQ; i++) begin
            applyStimulus(5, 1'b1, 12);
            #1;
            exp = itag_q.pop_front();
            void'(addr_q.pop_front());
            n_tests++;
            if (dsp_itag !== exp) begin n_fail++; $display("[TB] FAIL frd_fill_itag[%0d] got %0d exp %0d", i, dsp_itag, exp); end
            step();
        end
        applyStimulus(5, 1'b1, 13);
        void'(itag_q.pop_back());
        void'(addr_q.pop_back());
        retire_vld[5] = 1'b1;
        retire_cnt[5] = 4'd1;
        step();
        n_tests++;
        if (iq_rd_vld[5] !== 8'hFE) begin n_fail++; $display("[TB] FAIL frd_vld got %h exp fe", iq_rd_vld[5]); end
        n_tests++;
        if (dsp_rdy[5] !== 1'b1 || mcount[5] != 7) begin n_fail++; $display("[TB] FAIL frd_count7 got rdy %b exp 1", dsp_rdy[5]); end
        n_tests++;
        if (retire_itag[5] !== 3'd1) begin n_fail++; $display("[TB] FAIL frd_head got %0d exp 1", retire_itag[5]); end
        applyStimulus(5, 1'b1, 14);
        #1;
        exp = itag_q.pop_front();
        void'(addr_q.pop_front());
        n_tests++;
        if (dsp_itag !== exp) begin n_fail++; $display("[TB] FAIL frd_retry_itag got %0d exp %0d", dsp_itag, exp); end
        step();
        n_tests++;
        if (dsp_rdy[5] !== 1'b0 || iq_rd_vld[5] !== 8'hFF) begin n_fail++; $display("[TB] FAIL frd_count8 got rdy %b vld %h exp 0 ff", dsp_rdy[5], iq_rd_vld[5]); end
    endtask

    task automatic test_query();
        rst = 1'b1;
        step();
        rst = 1'b0;
        itag_q.delete();
        addr_q.delete();
        applyStimulus(3, 1'b1, 5);
        step();
        applyStimulus(3, 1'b0, 7);
        step();
        applyStimulus(3, 1'b1, 17);
        step();
        qry_tid = 3'd3; qry_addr = 5'd5; #1;
        n_tests++;
        if (qry_busy !== 1'b1) begin n_fail++; $display("[TB] FAIL qry_t3_a5 got %b exp 1", qry_busy); end
        qry_tid = 3'd4; qry_addr = 5'd5; #1;
        n_tests++;
        if (qry_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL qry_t4_a5 got %b exp 0", qry_busy); end
        qry_tid = 3'd3; qry_addr = 5'd7; #1;
        n_tests++;
        if (qry_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL qry_no_rd_vld got %b exp 0", qry_busy); end
        qry_tid = 3'd3; qry_addr = 5'd17; #1;
        n_tests++;
        if (qry_busy !== 1'b1) begin n_fail++; $display("[TB] FAIL qry_t3_a17 got %b exp 1", qry_busy); end
        retire_vld[3] = 1'b1;
        retire_cnt[3] = 4'd1;
        step();
        qry_tid = 3'd3; qry_addr = 5'd5; #1;
        n_tests++;
        if (qry_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL qry_after_retire got %b exp 0", qry_busy); end
        applyStimulus(3, 1'b1, 0);
        step();
        qry_tid = 3'd3; qry_addr = 5'd0; #1;
        n_tests++;
        if (qry_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL qry_x0 got %b exp 0", qry_busy); end
    endtask

    task automatic test_flush();
        itag_t exp;
        for (int i = 0; i < 3; i++) begin applyStimulus(1, 1'b1, 3 + i); step(); end
        for (int i = 0; i < 2; i++) begin applyStimulus(0, 1'b1, 8 + i); step(); end
        itag_q.delete();
        addr_q.delete();
        applyStimulus(1, 1'b1, 11);
        void'(itag_q.pop_back());
        void'(addr_q.pop_back());
        flush[1]      = 1'b1;
        retire_vld[0] = 1'b1;
        retire_cnt[0] = 4'd1;
        step();
        n_tests++;
        if (retire_rdy[1] !== 1'b0 || retire_itag[1] !== 3'd0) begin n_fail++; $display("[TB] FAIL flush_t1_empty got rdy %b head %0d exp 0 0", retire_rdy[1], retire_itag[1]); end
        n_tests++;
        if (iq_rd_vld[1] !== 8'h00) begin n_fail++; $display("[TB] FAIL flush_t1_vld got %h exp 00", iq_rd_vld[1]); end
        n_tests++;
        if (retire_itag[0] !== 3'd1 || iq_rd_vld[0] !== 8'b0000_0010) begin n_fail++; $display("[TB] FAIL flush_t0_retire got head %0d vld %b exp 1 00000010", retire_itag[0], iq_rd_vld[0]); end
        applyStimulus(1, 1'b1, 12);
        #1;
        exp = itag_q.pop_front();
        void'(addr_q.pop_front());
        n_tests++;
        if (dsp_itag !== exp) begin n_fail++; $display("[TB] FAIL flush_t1_tail got %0d exp %0d", dsp_itag, exp); end
        step();
    endtask

    task automatic test_reset_mid();
        itag_t exp;
        for (int i = 0; i < 3; i++) begin applyStimulus(6, 1'b1, 4); step(); end
        itag_q.delete();
        addr_q.delete();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_tests++;
        if (retire_rdy !== 8'h00 || iq_rd_vld !== '0) begin n_fail++; $display("[TB] FAIL rstmid_empty got %h exp 00", retire_rdy); end
        applyStimulus(6, 1'b1, 4);
        #1;
        exp = itag_q.pop_front();
        void'(addr_q.pop_front());
        n_tests++;
        if (dsp_itag !== exp || dsp_itag !== 3'd0) begin n_fail++; $display("[TB] FAIL rstmid_itag got %0d exp 0", dsp_itag); end
        step();
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        for (int t = 0; t < NT; t++) begin mcount[t] = 0; mtail[t] = 0; end
        test_reset();
        test_fill();
        test_full_ignore();
        test_retire_wrap();
        test_full_retire_dispatch();
        test_query();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
